// File: rtl/spi_tgt_shf_if.sv
// Signal bundle for the SPI target shifter: mode straps, SPI pins and the host word interface.
// slave is the shifter's view; master is the remote controller plus host side.
interface spi_tgt_shf_if #(
    parameter int DW = 8
);
    logic          clk_pol;
    logic          clk_pha;
    logic          lsb_first;
    logic          spi_sck;
    logic          spi_csn;
    logic          spi_mosi;
    logic          spi_miso;
    logic          spi_miso_oe;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          tx_undrn;
    logic          busy;

    modport slave (
        input  clk_pol, clk_pha, lsb_first, spi_sck, spi_csn, spi_mosi, tx_data, tx_valid,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_undrn, busy
    );

    modport master (
        output clk_pol, clk_pha, lsb_first, spi_sck, spi_csn, spi_mosi, tx_data, tx_valid,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_undrn, busy
    );
endinterface

// File: rtl/spi_tgt_shf.sv
// SPI target shifter: oversampled SCK/CS/MOSI, all four CPOL/CPHA modes, either bit order,
// single-word transmit holding buffer with underrun strobe.
//
// state  | meaning
// DISARM | after reset; ignores any frame in flight until CS is seen high
// IDLE   | CS high, waiting for frame start
// ACTIVE | CS low, shifting words
module spi_tgt_shf #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_in,
    input  logic         rst,
    spi_tgt_shf_if.slave bus
);
    typedef enum logic [1:0] {
        DISARM = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam int              CW       = $clog2(DW);
    localparam int              FW       = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DW - 1);
    localparam logic [FW-1:0]   FLUSH_LD = FW'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sck_d1_q;
    logic                   sck_s, csn_s, mosi_s;
    logic                   sck_edge, lead_edge, trail_edge, sample_edge, drive_edge;

    state_e        state_q, state_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] tx_sh_q, tx_sh_d;
    logic [DW-1:0] rx_sh_q, rx_sh_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          buf_full_q, buf_full_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          undrn_q, undrn_d;
    logic          miso_q, miso_d;

    logic          load;
    logic          accept;
    logic [DW-1:0] load_word;
    logic [DW-1:0] rx_word;

    function automatic logic first_bit(input logic [DW-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DW-1];
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DW-1:1]} : {w[DW-2:0], 1'b0};
    endfunction

    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic b,
                                               input logic lsb);
        return lsb ? {b, w[DW-1:1]} : {w[DW-2:0], b};
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_d1_q    <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], bus.spi_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            sck_d1_q    <= sck_s;
        end
    end

    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign csn_s       = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sck_edge    = sck_s ^ sck_d1_q;
    assign lead_edge   = sck_edge & (sck_s != bus.clk_pol);
    assign trail_edge  = sck_edge & (sck_s == bus.clk_pol);
    assign sample_edge = bus.clk_pha ? trail_edge : lead_edge;
    assign drive_edge  = bus.clk_pha ? lead_edge : trail_edge;

    // A load sees the buffer as it was at the start of the cycle, so a same-cycle accept survives.
    assign accept      = bus.tx_valid & ~buf_full_q;

    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        undrn_d    = 1'b0;
        miso_d     = miso_q;
        load       = 1'b0;
        load_word  = buf_full_q ? buf_q : '0;
        rx_word    = shift_in(rx_sh_q, mosi_s, bus.lsb_first);

        unique case (state_q)
            DISARM: begin
                // Synchronizers reset to CS high; wait for them to flush before trusting CS.
                if (flush_q != '0) begin
                    flush_d = flush_q - 1'b1;
                end else if (csn_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!csn_s) begin
                    state_d   = ACTIVE;
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                    if (bus.clk_pha) begin
                        tx_sh_d = load_word;
                    end else begin
                        miso_d  = first_bit(load_word, bus.lsb_first);
                        tx_sh_d = shift_out(load_word, bus.lsb_first);
                    end
                end
            end
            ACTIVE: begin
                if (sample_edge) begin
                    rx_sh_d = rx_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        // No reload when the frame is ending; the buffered word waits for the next frame.
                        if (!csn_s) begin
                            load    = 1'b1;
                            tx_sh_d = load_word;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (drive_edge) begin
                    miso_d  = first_bit(tx_sh_q, bus.lsb_first);
                    tx_sh_d = shift_out(tx_sh_q, bus.lsb_first);
                end
                if (csn_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                end
            end
            default: state_d = DISARM;
        endcase

        undrn_d = load & ~buf_full_q;
        if (accept) begin
            buf_d      = bus.tx_data;
            buf_full_d = 1'b1;
        end else if (load) begin
            buf_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= DISARM;
            flush_q    <= FLUSH_LD;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            undrn_q    <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            undrn_q    <= undrn_d;
            miso_q     <= miso_d;
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = (state_q == ACTIVE);
    assign bus.busy        = (state_q == ACTIVE);
    assign bus.tx_ready    = ~buf_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_undrn    = undrn_q;
endmodule

// File: tb/tb_spi_tgt_shf.sv
// Bench for spi_tgt_shf: a pin-level SPI controller plus a word-level model of the holding
// buffer, transmit stream and expected receive words.
module tb_spi_tgt_shf;
    localparam int DW   = 8;
    localparam int SYNC = 2;

    logic clk_in = 1'b0;
    logic rst;

    spi_tgt_shf_if #(.DW(DW)) bus ();

    spi_tgt_shf #(.DW(DW), .SYNC_STAGES(SYNC)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    bit            cpol, cpha, lsb;
    bit            m_full;
    bit [DW-1:0]   m_buf;
    bit [DW-1:0]   exp_rx_q[$];
    int            exp_undrn = 0;
    int            got_undrn = 0;
    int            got_rx    = 0;
    int            last_undrn;
    int            first_undrn;

    bit [DW-1:0]   mosi_arr[4];
    bit            push_en[4];
    bit [DW-1:0]   push_val[4];
    logic [DW-1:0] cap_words[4];

    logic rst_seen = 1'b0;
    logic prev_rxv = 1'b0;
    logic prev_und = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk_in) rst_seen <= rst;

    // Per-cycle compare against the model's expected receive words and reset values.
    always @(negedge clk_in) begin
        if (rst_seen) begin
            check("reset_outputs",
                  {bus.spi_miso, bus.spi_miso_oe, bus.rx_data, bus.rx_valid, bus.tx_undrn,
                   bus.busy, bus.tx_ready}, 32'd1);
        end else begin
            if (bus.rx_valid === 1'b1) begin
                got_rx++;
                check("rx_valid_width", prev_rxv, 0);
                check("rx_pending", exp_rx_q.size() > 0, 1);
                if (exp_rx_q.size() > 0) check("rx_data", bus.rx_data, exp_rx_q.pop_front());
            end
            if (bus.tx_undrn === 1'b1) begin
                got_undrn++;
                check("undrn_width", prev_und, 0);
            end
        end
        prev_rxv = bus.rx_valid;
        prev_und = bus.tx_undrn;
    end

    task automatic half(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    function automatic bit bitof(input bit [DW-1:0] wd, input int k);
        return lsb ? wd[k] : wd[DW-1-k];
    endfunction

    task automatic model_load(output bit [DW-1:0] w);
        if (m_full) begin
            w      = m_buf;
            m_full = 1'b0;
        end else begin
            w = '0;
            exp_undrn++;
        end
    endtask

    task automatic model_accept(input bit [DW-1:0] w);
        if (!m_full) begin
            m_buf  = w;
            m_full = 1'b1;
        end
    endtask

    task automatic pulse_tx(input bit [DW-1:0] w);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        half(1);
        bus.tx_valid = 1'b0;
        model_accept(w);
    endtask

    task automatic set_mode(input bit p, input bit h, input bit l);
        cpol = p; cpha = h; lsb = l;
        bus.clk_pol   = p;
        bus.clk_pha   = h;
        bus.lsb_first = l;
        bus.spi_sck   = p;
        half(10);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 4; i++) begin
            push_en[i]  = 1'b0;
            push_val[i] = '0;
            mosi_arr[i] = DW'($urandom);
        end
    endtask

    task automatic sample_check(input int w, input int k, input int b, input bit eb);
        check("miso_bit", bus.spi_miso, eb);
        if (lsb) cap_words[w][k] = bus.spi_miso;
        else     cap_words[w][DW-1-k] = bus.spi_miso;
        if (b == 0) begin
            check("active_oe_busy", {bus.spi_miso_oe, bus.busy}, 2'b11);
            first_undrn = got_undrn;
        end
        if (k == 3) check("tx_ready_mid", bus.tx_ready, !m_full);
    endtask

    task automatic end_of_bit(input int w, input int k, inout bit [DW-1:0] cur);
        if (k == DW-1) begin
            exp_rx_q.push_back(mosi_arr[w]);
            last_undrn = got_undrn;
            model_load(cur);
        end
    endtask

    task automatic run_frame(input int nwords, input int extra, input int hp,
                             input bit start_push, input bit [DW-1:0] spv);
        int nbits;
        int w, k;
        bit [DW-1:0] cur;
        nbits = nwords * DW + extra;
        for (int i = 0; i < 4; i++) cap_words[i] = '0;
        bus.spi_csn = 1'b0;
        model_load(cur);
        if (!cpha) bus.spi_mosi = bitof(mosi_arr[0], 0);
        if (start_push) begin
            // Lands tx_valid on the clock edge where the frame-start load happens.
            half(SYNC);
            pulse_tx(spv);
            half(hp - SYNC - 1);
        end else begin
            half(hp);
        end
        for (int b = 0; b < nbits; b++) begin
            w = b / DW;
            k = b % DW;
            if (!cpha) begin
                sample_check(w, k, b, bitof(cur, k));
                bus.spi_sck = ~cpol;
                end_of_bit(w, k, cur);
                half(hp);
                bus.spi_sck = cpol;
                if (b + 1 < nbits) bus.spi_mosi = bitof(mosi_arr[(b+1)/DW], (b+1)%DW);
                if (k == 1 && push_en[w]) begin
                    pulse_tx(push_val[w]);
                    half(hp - 1);
                end else begin
                    half(hp);
                end
            end else begin
                bus.spi_sck  = ~cpol;
                bus.spi_mosi = bitof(mosi_arr[w], k);
                if (k == 1 && push_en[w]) begin
                    pulse_tx(push_val[w]);
                    half(hp - 1);
                end else begin
                    half(hp);
                end
                sample_check(w, k, b, bitof(cur, k));
                bus.spi_sck = cpol;
                end_of_bit(w, k, cur);
                half(hp);
            end
        end
        half(hp);
        bus.spi_csn = 1'b1;
        half(hp + 8);
        check("idle_oe_busy", {bus.spi_miso_oe, bus.busy}, 2'b00);
        check("tx_ready_idle", bus.tx_ready, !m_full);
        check("rx_all_seen", exp_rx_q.size(), 0);
        check("undrn_count", got_undrn, exp_undrn);
    endtask

    initial begin
        int pre_rx, pre_und;
        rst           = 1'b1;
        bus.clk_pol   = 1'b0;
        bus.clk_pha   = 1'b0;
        bus.lsb_first = 1'b0;
        bus.spi_sck   = 1'b0;
        bus.spi_csn   = 1'b1;
        bus.spi_mosi  = 1'b0;
        bus.tx_data   = '0;
        bus.tx_valid  = 1'b0;
        m_full        = 1'b0;
        m_buf         = '0;
        half(4);
        rst = 1'b0;
        half(10);
        check("tx_ready_after_reset", bus.tx_ready, 1);

        // Mode 0, MSB first, 0xA5 out, 0x3C in.
        set_mode(0, 0, 0);
        clear_plan();
        pulse_tx(8'hA5);
        mosi_arr[0] = 8'h3C;
        pre_rx = got_rx;
        run_frame(1, 0, 8, 0, '0);
        check("s024_miso_word", cap_words[0], 8'hA5);
        check("s024_rx_data", bus.rx_data, 8'h3C);
        check("s024_rx_count", got_rx - pre_rx, 1);

        // Mode 3, LSB first, two back-to-back words.
        set_mode(1, 1, 1);
        clear_plan();
        pulse_tx(8'h01);
        push_en[0]  = 1'b1;
        push_val[0] = 8'h80;
        pre_rx  = got_rx;
        pre_und = got_undrn;
        run_frame(2, 0, 6, 0, '0);
        check("s025_miso_w0", cap_words[0], 8'h01);
        check("s025_miso_w1", cap_words[1], 8'h80);
        check("s025_rx_count", got_rx - pre_rx, 2);
        check("s025_no_undrn", last_undrn - pre_und, 0);

        // Frame start with the buffer empty.
        set_mode(0, 0, 0);
        clear_plan();
        pre_und = got_undrn;
        run_frame(1, 0, 7, 0, '0);
        check("s026_undrn_start", first_undrn - pre_und, 1);
        check("s026_miso_zero", cap_words[0], 8'h00);
        check("s026_tx_ready", bus.tx_ready, 1);

        // CS raised after 5 SCK cycles, then a full frame from bit 0.
        clear_plan();
        pre_rx = got_rx;
        run_frame(0, 5, 6, 0, '0);
        check("s027_no_rx", got_rx - pre_rx, 0);
        clear_plan();
        mosi_arr[0] = 8'h96;
        run_frame(1, 0, 6, 0, '0);
        check("s027_rx_data", bus.rx_data, 8'h96);
        check("s027_rx_count", got_rx - pre_rx, 1);

        // Reset mid-frame with CS held low; the rest of that frame must be ignored.
        begin
            bit [DW-1:0] dummy;
            set_mode(0, 0, 0);
            pre_rx = got_rx;
            bus.spi_csn = 1'b0;
            model_load(dummy);
            for (int i = 0; i < 3; i++) begin
                half(6); bus.spi_sck = 1'b1;
                half(6); bus.spi_sck = 1'b0;
            end
            rst = 1'b1;
            half(2);
            rst    = 1'b0;
            m_full = 1'b0;
            for (int i = 0; i < 10; i++) begin
                bus.spi_mosi = 1'($urandom);
                half(6); bus.spi_sck = 1'b1;
                half(6);
                check("s028_disarm_oe_busy", {bus.spi_miso_oe, bus.busy}, 2'b00);
                bus.spi_sck = 1'b0;
            end
            half(6);
            bus.spi_csn = 1'b1;
            half(12);
            check("s028_no_rx", got_rx - pre_rx, 0);
            check("s028_tx_ready", bus.tx_ready, 1);
            clear_plan();
            pulse_tx(8'h3E);
            mosi_arr[0] = 8'hC3;
            run_frame(1, 0, 6, 0, '0);
            check("s028_rx_after", bus.rx_data, 8'hC3);
            check("s028_miso_after", cap_words[0], 8'h3E);
        end

        // tx_valid coincident with an empty-buffer frame-start load.
        set_mode(0, 0, 0);
        clear_plan();
        pre_und = got_undrn;
        run_frame(2, 0, 8, 1, 8'h5A);
        check("s029_miso_w0", cap_words[0], 8'h00);
        check("s029_miso_w1", cap_words[1], 8'h5A);
        check("s029_undrn_total", got_undrn - pre_und, 2);

        // Randomized frames across all modes and bit orders.
        for (int f = 0; f < 20; f++) begin
            int nw, ex, hp;
            set_mode(1'($urandom), 1'($urandom), 1'($urandom));
            clear_plan();
            for (int i = 0; i < 4; i++) begin
                push_en[i]  = 1'($urandom);
                push_val[i] = DW'($urandom);
            end
            if ($urandom_range(0, 1) == 1) pulse_tx(DW'($urandom));
            half(4);
            nw = $urandom_range(1, 3);
            ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
            hp = $urandom_range(5, 10);
            run_frame(nw, ex, hp, 0, '0);
        end

        half(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
